saph_pixel_pack: RTL and testbench

Streaming pixel packer for the Sapphire GPU pixel path. It takes multi-channel pixels, one per handshake, and reduces each channel to a per-channel bit width by keeping its most-significant bits. Each reduced pixel is concatenated into a continuous bitstream, and the stream leaves as fixed-width packed words. Pixels may straddle word boundaries. A flush marker emits any partial word zero-padded, so the block can sit between the shader output stage and the framebuffer write port for any RGB/RGBA packed format.

---
 rtl/saph_pack_pkg.sv | 19 +
 rtl/saph_pixel_concat.sv | 39 +++
 rtl/saph_pixel_pack.sv | 154 +++++++++++++++
 tb/tb_saph_pixel_pack.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/saph_pack_pkg.sv
// Shared types and width helpers for the Sapphire pixel packer.
package saph_pack_pkg;

  typedef enum logic [0:0] {
    SAPH_PACK_RUN   = 1'b0,
    SAPH_PACK_EMIT2 = 1'b1
  } saph_pack_state_e;

  // Width of a count that must represent 0..pack_width inclusive.
  function automatic int fill_width(input int pack_width);
    return $clog2(pack_width + 1);
  endfunction

  // Width of one per-channel cfg field holding 0..unpack_width inclusive.
  function automatic int cfg_field_width(input int unpack_width);
    return $clog2(unpack_width + 1);
  endfunction

endpackage

// File: rtl/saph_pixel_concat.sv
// Combinational per-channel MSB reduction and LSB-first concatenation of one pixel.
module saph_pixel_concat
  import saph_pack_pkg::*;
#(
  parameter int unsigned UnpackWidth = 8,
  parameter int unsigned Channels    = 4,
  localparam int unsigned PixW       = Channels * UnpackWidth,
  localparam int unsigned CfgW       = cfg_field_width(UnpackWidth),
  localparam int unsigned PbW        = $clog2(PixW + 1)
) (
  input  logic [PixW-1:0]          i_data,
  input  logic [Channels*CfgW-1:0] i_cfg,
  output logic [PixW-1:0]          o_pix,
  output logic [PbW-1:0]           o_pb
);

  logic [PixW-1:0]        w_pix;
  logic [PbW-1:0]         w_pb;
  logic [CfgW-1:0]        w_wk;
  logic [UnpackWidth-1:0] w_red;

  // A zero width shifts the whole channel out, so it contributes no bits.
  always_comb begin
    w_pix = '0;
    w_pb  = '0;
    w_wk  = '0;
    w_red = '0;
    for (int k = 0; k < Channels; k++) begin
      w_wk  = i_cfg[k*CfgW +: CfgW];
      w_red = i_data[k*UnpackWidth +: UnpackWidth] >> (CfgW'(UnpackWidth) - w_wk);
      w_pix = w_pix | (PixW'(w_red) << w_pb);
      w_pb  = w_pb + PbW'(w_wk);
    end
  end

  assign o_pix = w_pix;
  assign o_pb  = w_pb;

endmodule

// File: rtl/saph_pixel_pack.sv
// Streaming pixel packer: reduces channels, concatenates pixels into a bitstream and
// emits fixed-width words, with flush producing a zero-padded final partial word.
module saph_pixel_pack
  import saph_pack_pkg::*;
#(
  parameter int unsigned PackWidth   = 32,
  parameter int unsigned UnpackWidth = 8,
  parameter int unsigned Channels    = 4,
  localparam int unsigned PixW       = Channels * UnpackWidth,
  localparam int unsigned CfgW       = cfg_field_width(UnpackWidth),
  localparam int unsigned FillW      = fill_width(PackWidth)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [PixW-1:0]          i_in_data,
  input  logic [Channels*CfgW-1:0] i_cfg_width,
  input  logic                     i_in_flush,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  output logic [PackWidth-1:0]     o_out_data,
  output logic [FillW-1:0]         o_out_fill,
  output logic                     o_out_last,
  output logic                     o_out_valid,
  input  logic                     i_out_ready
);

  localparam int unsigned AccW = 2 * PackWidth;
  localparam int unsigned SumW = FillW + 1;
  localparam int unsigned PbW  = $clog2(PixW + 1);

  saph_pack_state_e       r_state, w_state_nxt;
  logic [AccW-1:0]        r_acc, w_acc_nxt;
  logic [FillW-1:0]       r_fill, w_fill_nxt;
  logic [PackWidth-1:0]   r_out_data, w_out_data_nxt;
  logic [FillW-1:0]       r_out_fill, w_out_fill_nxt;
  logic                   r_out_last, w_out_last_nxt;
  logic                   r_out_valid, w_out_valid_nxt;

  logic [PixW-1:0]        w_pix;
  logic [PbW-1:0]         w_pb;
  logic [AccW-1:0]        w_merged;
  logic [AccW-1:0]        w_shifted;
  logic [SumW-1:0]        w_sum;
  logic [SumW-1:0]        w_rem;
  logic                   w_full;
  logic                   w_accept;
  logic                   w_out_hs;

  saph_pixel_concat #(
    .UnpackWidth (UnpackWidth),
    .Channels    (Channels)
  ) u_concat (
    .i_data (i_in_data),
    .i_cfg  (i_cfg_width),
    .o_pix  (w_pix),
    .o_pb   (w_pb)
  );

  assign o_in_ready = (r_state == SAPH_PACK_RUN) && (!r_out_valid || i_out_ready);
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_out_hs   = r_out_valid && i_out_ready;

  assign w_merged  = r_acc | (AccW'(w_pix) << r_fill);
  assign w_sum     = SumW'(r_fill) + SumW'(w_pb);
  assign w_full    = (w_sum >= SumW'(PackWidth));
  assign w_rem     = w_full ? (w_sum - SumW'(PackWidth)) : w_sum;
  assign w_shifted = w_full ? (w_merged >> PackWidth) : w_merged;

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_fill_nxt      = r_fill;
    w_out_data_nxt  = r_out_data;
    w_out_fill_nxt  = r_out_fill;
    w_out_last_nxt  = r_out_last;
    w_out_valid_nxt = r_out_valid;
    if (w_out_hs) begin
      w_out_valid_nxt = 1'b0;
    end
    unique case (r_state)
      SAPH_PACK_RUN: begin
        if (w_accept) begin
          if (w_full) begin
            w_out_data_nxt  = w_merged[PackWidth-1:0];
            w_out_fill_nxt  = FillW'(PackWidth);
            w_out_last_nxt  = i_in_flush && (w_rem == '0);
            w_out_valid_nxt = 1'b1;
          end
          if (i_in_flush) begin
            if (w_rem != '0) begin
              if (w_full) begin
                // Partial waits in the accumulator until the full word is taken.
                w_state_nxt = SAPH_PACK_EMIT2;
                w_acc_nxt   = w_shifted;
                w_fill_nxt  = FillW'(w_rem);
              end else begin
                w_out_data_nxt  = w_shifted[PackWidth-1:0];
                w_out_fill_nxt  = FillW'(w_rem);
                w_out_last_nxt  = 1'b1;
                w_out_valid_nxt = 1'b1;
                w_acc_nxt       = '0;
                w_fill_nxt      = '0;
              end
            end else begin
              w_acc_nxt  = '0;
              w_fill_nxt = '0;
            end
          end else begin
            w_acc_nxt  = w_shifted;
            w_fill_nxt = FillW'(w_rem);
          end
        end
      end
      SAPH_PACK_EMIT2: begin
        if (w_out_hs) begin
          w_out_data_nxt  = r_acc[PackWidth-1:0];
          w_out_fill_nxt  = r_fill;
          w_out_last_nxt  = 1'b1;
          w_out_valid_nxt = 1'b1;
          w_acc_nxt       = '0;
          w_fill_nxt      = '0;
          w_state_nxt     = SAPH_PACK_RUN;
        end
      end
      default: w_state_nxt = SAPH_PACK_RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= SAPH_PACK_RUN;
      r_acc       <= '0;
      r_fill      <= '0;
      r_out_data  <= '0;
      r_out_fill  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_fill      <= w_fill_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_fill  <= w_out_fill_nxt;
      r_out_last  <= w_out_last_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_fill  = r_out_fill;
  assign o_out_last  = r_out_last;
  assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_saph_pixel_pack.sv
// Scoreboard bench for saph_pixel_pack: directed pixels push expected words, a monitor checks them.
module tb_saph_pixel_pack;

  typedef struct {
    logic [31:0] d;
    logic [5:0]  f;
    logic        l;
  } exp_t;

  localparam logic [31:0] Px565  = 32'h00FF00FF;
  localparam logic [15:0] Cfg565 = 16'h0565;
  localparam logic [15:0] Cfg888 = 16'h0888;

  logic        clk;
  logic        rst_n;
  logic [31:0] i_in_data;
  logic [15:0] i_cfg_width;
  logic        i_in_flush;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [31:0] o_out_data;
  logic [5:0]  o_out_fill;
  logic        o_out_last;
  logic        o_out_valid;
  logic        i_out_ready;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  saph_pixel_pack #(
    .PackWidth   (32),
    .UnpackWidth (8),
    .Channels    (4)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_data   (i_in_data),
    .i_cfg_width (i_cfg_width),
    .i_in_flush  (i_in_flush),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .o_out_data  (o_out_data),
    .o_out_fill  (o_out_fill),
    .o_out_last  (o_out_last),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [5:0] f, input logic l);
    exp_t e;
    e.d = d;
    e.f = f;
    e.l = l;
    q.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] d, input logic [15:0] c, input logic f);
    int budget = 50;
    i_in_valid  = 1'b1;
    i_in_data   = d;
    i_cfg_width = c;
    i_in_flush  = f;
    @(negedge clk);
    while (!o_in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!o_in_ready) chk("send_timeout", {63'd0, o_in_ready}, 64'd1);
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    i_in_flush = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && o_out_valid && i_out_ready) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_word: got 0x%0h fill %0d last %0b, expected no word",
                 o_out_data, o_out_fill, o_out_last);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("word{data,fill,last}", {25'd0, o_out_data, o_out_fill, o_out_last},
            {25'd0, e.d, e.f, e.l});
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    i_in_data   = '0;
    i_cfg_width = '0;
    i_in_flush  = 1'b0;
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    #3;
    chk("rst_valid", {63'd0, o_out_valid}, 64'd0);
    chk("rst_data", {32'd0, o_out_data}, 64'd0);
    chk("rst_fill", {58'd0, o_out_fill}, 64'd0);
    chk("rst_last", {63'd0, o_out_last}, 64'd0);
    chk("rst_in_ready", {63'd0, o_in_ready}, 64'd1);
    #19 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // RGB565 pair -> one full word, valid the cycle after the second accept
    push(32'hF81FF81F, 6'd32, 1'b0);
    send(Px565, Cfg565, 1'b0);
    send(Px565, Cfg565, 1'b0);
    chk("565_latency_valid", {63'd0, o_out_valid}, 64'd1);
    chk("565_latency_data", {32'd0, o_out_data}, 64'hF81FF81F);

    // RGB888 straddle, then a flushing third pixel exercises the 16 leftover bits
    push(32'h44112233, 6'd32, 1'b0);
    push(32'h88776655, 6'd32, 1'b0);
    push(32'h00000099, 6'd8, 1'b1);
    send(32'h00112233, Cfg888, 1'b0);
    send(32'h00665544, Cfg888, 1'b0);
    send(32'h00998877, Cfg888, 1'b1);

    // Two-word flush: in_ready low while the partial is pending
    push(32'h44112233, 6'd32, 1'b0);
    push(32'h00006655, 6'd16, 1'b1);
    send(32'h00112233, Cfg888, 1'b0);
    send(32'h00665544, Cfg888, 1'b1);
    chk("emit2_in_ready", {63'd0, o_in_ready}, 64'd0);

    // Full word that exactly empties the stream carries last
    push(32'hF81FF81F, 6'd32, 1'b1);
    send(Px565, Cfg565, 1'b0);
    send(Px565, Cfg565, 1'b1);

    // Single-pixel flush, then an empty flush that must emit nothing
    push(32'h0000F81F, 6'd16, 1'b1);
    send(Px565, Cfg565, 1'b1);
    send(Px565, 16'h0000, 1'b1);
    chk("empty_flush_valid0", {63'd0, o_out_valid}, 64'd0);
    @(posedge clk);
    #1;
    chk("empty_flush_valid1", {63'd0, o_out_valid}, 64'd0);

    // Backpressure with a pixel waiting
    i_out_ready = 1'b0;
    push(32'hF81FF81F, 6'd32, 1'b0);
    send(Px565, Cfg565, 1'b0);
    send(Px565, Cfg565, 1'b0);
    push(32'h0000F81F, 6'd16, 1'b1);
    i_in_valid  = 1'b1;
    i_in_data   = Px565;
    i_cfg_width = Cfg565;
    i_in_flush  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", {63'd0, o_out_valid}, 64'd1);
      chk("bp_data", {32'd0, o_out_data}, 64'hF81FF81F);
      chk("bp_in_ready", {63'd0, o_in_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    i_out_ready = 1'b1;
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    i_in_flush = 1'b0;
    chk("bp_next_valid", {63'd0, o_out_valid}, 64'd1);
    chk("bp_next_data", {32'd0, o_out_data}, 64'h0000F81F);
    @(posedge clk);
    #1;

    // Reset while in EMIT2 discards both pending words
    i_out_ready = 1'b0;
    send(32'h00112233, Cfg888, 1'b0);
    send(32'h00665544, Cfg888, 1'b1);
    chk("pre_reset_in_ready", {63'd0, o_in_ready}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_valid", {63'd0, o_out_valid}, 64'd0);
    chk("reset_in_ready", {63'd0, o_in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    i_out_ready = 1'b1;
    push(32'hF81FF81F, 6'd32, 1'b0);
    push(32'h0000F81F, 6'd16, 1'b1);
    send(Px565, Cfg565, 1'b0);
    send(Px565, Cfg565, 1'b0);
    send(Px565, Cfg565, 1'b1);

    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
